uart_cmd_parser: RTL and testbench

Parametrised UART command-frame parser sitting between the UART receiver (`rx_data`/`rx_done`) and the register/control logic it drives. It tracks frames with an explicit state machine: two header bytes, a configurable payload, an optional 8-bit checksum and a tail byte. Every good frame is latched into a wide payload register with a one-cycle valid pulse. Errors (checksum, tail, inter-byte timeout) are reported with an error pulse and code, and the parser resynchronises on the next header.

---
 rtl/uart_cmd_parser.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames bytes from a UART receiver into fixed-length commands.
// Frame layout: HEAD0 HEAD1 payload[PAYLOAD_BYTES] [checksum if CHK_EN] TAIL.
// Ports:
//   sys_clk, rst         clock, asynchronous active-high reset
//   rx_data, rx_done     received byte and its one-cycle strobe
//   payload_out          last good payload, byte 0 (first received) in the LSBs
//   frame_valid          one-cycle pulse when payload_out updates
//   frame_err, err_code  one-cycle error pulse; code 01 checksum, 10 tail, 11 timeout (sticky)
//   frame_cnt            good-frame counter, wraps
module uart_cmd_parser #(
  parameter int unsigned PAYLOAD_BYTES = 5,
  parameter logic [7:0]  HEAD0         = 8'h5A,
  parameter logic [7:0]  HEAD1         = 8'h86,
  parameter logic [7:0]  TAIL          = 8'hEA,
  parameter bit          CHK_EN        = 1'b1,
  parameter int unsigned TIMEOUT_CYC   = 100000
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_done,
  output logic [8*PAYLOAD_BYTES-1:0]   payload_out,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic [1:0]                   err_code,
  output logic [15:0]                  frame_cnt
);

  localparam int unsigned    IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
  // Expiry is detected one count early so the registered error lands exactly
  // TIMEOUT_CYC edges after the last accepted byte.
  localparam logic [31:0]    TO_LAST  = 32'(TIMEOUT_CYC) - 32'd1;

  typedef enum logic [2:0] {StIdle, StHdr1, StPayload, StCheck, StTail} state_e;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q;
  logic [7:0]                   acc_q;
  logic [8*PAYLOAD_BYTES-1:0]   shadow_q;
  logic [31:0]                  idle_cnt_q;
  logic                         timeout_hit;
  logic                         byte_last;
  logic                         valid_d, err_d;
  logic [1:0]                   code_d;

  assign byte_last   = (idx_q == LAST_IDX);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q != StIdle) && !rx_done &&
                       (idle_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (rx_done) begin
      case (state_q)
        StIdle:    if (rx_data == HEAD0) state_d = StHdr1;
        StHdr1: begin
          if (rx_data == HEAD1)      state_d = StPayload;
          else if (rx_data == HEAD0) state_d = StHdr1;
          else                       state_d = StIdle;
        end
        StPayload: if (byte_last) state_d = CHK_EN ? StCheck : StTail;
        StCheck:   state_d = (rx_data == acc_q) ? StTail : StIdle;
        StTail:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end else if (timeout_hit) begin
      state_d = StIdle;
    end
  end

  // Output next values (registered below)
  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code;
    if (rx_done) begin
      if (state_q == StCheck && rx_data != acc_q) begin
        err_d  = 1'b1;
        code_d = 2'b01;
      end else if (state_q == StTail) begin
        if (rx_data == TAIL) begin
          valid_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          code_d = 2'b10;
        end
      end
    end else if (timeout_hit) begin
      err_d  = 1'b1;
      code_d = 2'b11;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      payload_out <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      frame_cnt   <= 16'd0;
    end else begin
      frame_valid <= valid_d;
      frame_err   <= err_d;
      err_code    <= code_d;
      if (valid_d) begin
        payload_out <= shadow_q;
        frame_cnt   <= frame_cnt + 16'd1;
      end
    end
  end

  // Datapath: byte index, checksum accumulator, shadow buffer, idle counter
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      acc_q      <= 8'd0;
      shadow_q   <= '0;
      idle_cnt_q <= 32'd0;
    end else begin
      if (rx_done || state_q == StIdle || TIMEOUT_CYC == 0) idle_cnt_q <= 32'd0;
      else                                                idle_cnt_q <= idle_cnt_q + 32'd1;

      if (rx_done) begin
        if (state_q == StHdr1 && rx_data == HEAD1) begin
          idx_q <= '0;
          acc_q <= 8'd0;
        end else if (state_q == StPayload) begin
          for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
            if (idx_q == IDX_W'(i)) shadow_q[8*i +: 8] <= rx_data;
          end
          acc_q <= acc_q + rx_data;
          idx_q <= byte_last ? '0 : idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser. Three instances share rx_data and reset:
//   a: PAYLOAD_BYTES=5, CHK_EN=1, TIMEOUT_CYC=1000
//   b: PAYLOAD_BYTES=5, CHK_EN=1, TIMEOUT_CYC=0
//   c: PAYLOAD_BYTES=1, CHK_EN=0, TIMEOUT_CYC=1000
// rx_done is steered to one instance at a time by sel.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  int         sel;

  logic        rd_a, rd_b, rd_c;
  logic [39:0] pa, pb;
  logic [7:0]  pc;
  logic        va, vb, vc, ea, eb, ec;
  logic [1:0]  ca_code, cb_code, cc_code;
  logic [15:0] na, nb, nc;

  assign rd_a = rx_done && (sel == 0);
  assign rd_b = rx_done && (sel == 1);
  assign rd_c = rx_done && (sel == 2);

  always #5 clk = ~clk;

  uart_cmd_parser #(.PAYLOAD_BYTES(5), .CHK_EN(1'b1), .TIMEOUT_CYC(1000)) dut_a (
    .sys_clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rd_a), .payload_out(pa),
    .frame_valid(va), .frame_err(ea), .err_code(ca_code), .frame_cnt(na)
  );
  uart_cmd_parser #(.PAYLOAD_BYTES(5), .CHK_EN(1'b1), .TIMEOUT_CYC(0)) dut_b (
    .sys_clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rd_b), .payload_out(pb),
    .frame_valid(vb), .frame_err(eb), .err_code(cb_code), .frame_cnt(nb)
  );
  uart_cmd_parser #(.PAYLOAD_BYTES(1), .CHK_EN(1'b0), .TIMEOUT_CYC(1000)) dut_c (
    .sys_clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rd_c), .payload_out(pc),
    .frame_valid(vc), .frame_err(ec), .err_code(cc_code), .frame_cnt(nc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int nva = 0, nea = 0, neb = 0, nboth = 0;

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (va) nva++;
    if (ea) nea++;
    if (eb) neb++;
    if ((va && ea) || (vb && eb) || (vc && ec)) nboth++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the capturing edge.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Sends n bytes back-to-back, first byte in the most significant occupied slot.
  task automatic send_vec(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  int snap;
  int waited;

  initial begin
    sel = 0; rx_data = 8'h00; rx_done = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_payload", pa, 40'h0);
    check_eq("rst_valid", va, 1'b0);
    check_eq("rst_err", ea, 1'b0);
    check_eq("rst_code", ca_code, 2'b00);
    check_eq("rst_cnt", na, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame; checksum 11+22+33+44+55 = FF
    send_vec(72'h5A_86_11_22_33_44_55_FF_EA, 9);
    check_eq("good_valid", va, 1'b1);
    check_eq("good_payload", pa, 40'h5544332211);
    check_eq("good_cnt", na, 16'd1);
    check_eq("good_noerr", ea, 1'b0);
    @(negedge clk);
    check_eq("good_valid_width", va, 1'b0);

    // Bad checksum, then the stray tail is ignored in IDLE
    send_vec(64'h5A_86_11_22_33_44_55_00, 8);
    check_eq("chk_err", ea, 1'b1);
    check_eq("chk_code", ca_code, 2'b01);
    send(8'hEA);
    check_eq("chk_err_width", ea, 1'b0);
    check_eq("chk_novalid", va, 1'b0);
    check_eq("chk_payload_kept", pa, 40'h5544332211);
    check_eq("chk_cnt_kept", na, 16'd1);

    // AA+BB+CC+DD+EE = 0x3FC -> checksum FC
    send_vec(72'h5A_86_AA_BB_CC_DD_EE_FC_EA, 9);
    check_eq("aa_valid", va, 1'b1);
    check_eq("aa_payload", pa, 40'hEEDDCCBBAA);
    check_eq("aa_cnt", na, 16'd2);

    // Wrong tail
    send_vec(72'h5A_86_11_22_33_44_55_FF_EB, 9);
    check_eq("tail_err", ea, 1'b1);
    check_eq("tail_code", ca_code, 2'b10);
    check_eq("tail_novalid", va, 1'b0);
    check_eq("tail_cnt_kept", na, 16'd2);
    settle();
    snap = nea;

    // Resync on repeated HEAD0; checksum 01+..+05 = 0F
    send_vec(88'h00_5A_5A_86_01_02_03_04_05_0F_EA, 11);
    check_eq("resync_valid", va, 1'b1);
    check_eq("resync_payload", pa, 40'h0504030201);
    check_eq("resync_cnt", na, 16'd3);
    settle();
    check_eq("resync_noerr", nea - snap, 0);

    // Timeout after a partial frame
    send_vec(24'h5A_86_11, 3);
    waited = 0;
    while (!ea && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("to_delay", waited, 1000);
    check_eq("to_code", ca_code, 2'b11);
    @(negedge clk);
    check_eq("to_err_width", ea, 1'b0);

    // Two good frames back-to-back after the timeout
    snap = nva;
    send_vec(72'h5A_86_11_22_33_44_55_FF_EA, 9);
    send_vec(72'h5A_86_AA_BB_CC_DD_EE_FC_EA, 9);
    check_eq("b2b_payload", pa, 40'hEEDDCCBBAA);
    check_eq("b2b_cnt", na, 16'd5);
    settle();
    check_eq("b2b_pulses", nva - snap, 2);

    // Reset in the middle of a frame
    send_vec(32'h5A_86_11_22, 4);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_payload", pa, 40'h0);
    check_eq("mid_rst_cnt", na, 16'd0);
    check_eq("mid_rst_code", ca_code, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_vec(72'h5A_86_11_22_33_44_55_FF_EA, 9);
    check_eq("post_rst_valid", va, 1'b1);
    check_eq("post_rst_payload", pa, 40'h5544332211);
    check_eq("post_rst_cnt", na, 16'd1);

    // Timeout disabled: long gap mid-frame is harmless
    sel = 1;
    @(negedge clk);
    send_vec(24'h5A_86_11, 3);
    repeat (5000) @(negedge clk);
    settle();
    check_eq("noto_noerr", neb, 0);
    send_vec(48'h22_33_44_55_FF_EA, 6);
    check_eq("noto_valid", vb, 1'b1);
    check_eq("noto_payload", pb, 40'h5544332211);
    check_eq("noto_cnt", nb, 16'd1);

    // Single-byte payload, no checksum byte
    sel = 2;
    @(negedge clk);
    send_vec(32'h5A_86_7E_EA, 4);
    check_eq("c_valid", vc, 1'b1);
    check_eq("c_payload", pc, 8'h7E);
    check_eq("c_cnt", nc, 16'd1);
    settle();
    check_eq("valid_err_overlap", nboth, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
